sdram_arbiter: RTL

- Shares the single SDRAM controller command port between N_REQ burst requesters: display scanout, CPU/bus bridge, and DMA/spare.
- Requester 0 (scanout) has fixed high priority, bounded by a starvation limit. The remaining requesters are served round-robin.
- The grant is held from command issue until the controller reports burst completion. During that time the grant ID steers the data-path muxes outside this block.
- Sits between the requester ports and the SDRAM controller in clk_sys.

---
 rtl/sdram_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller command port between N_REQ burst
// requesters. Requester 0 has bounded fixed priority; the rest are served
// round-robin. The grant is held from command issue until ctrl_done.
module sdram_arbiter #(
    parameter int unsigned N_REQ     = 3,
    parameter int unsigned W_ADDR    = 24,
    parameter int unsigned W_LEN     = 4,
    parameter int unsigned MAX_HIPRI = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*W_ADDR-1:0] req_addr,
    input  logic [N_REQ-1:0]        req_write,
    input  logic [N_REQ*W_LEN-1:0]  req_len,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [W_ADDR-1:0]       cmd_addr,
    output logic                    cmd_write,
    output logic [W_LEN-1:0]        cmd_len,
    input  logic                    ctrl_done,
    output logic                    gnt_busy,
    output logic [2:0]              gnt_id
);

    localparam int unsigned W_ID = 3;
    localparam int unsigned W_HP = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [W_ADDR-1:0]   cmd_addr_q, cmd_addr_d;
    logic                cmd_write_q, cmd_write_d;
    logic [W_LEN-1:0]    cmd_len_q, cmd_len_d;
    logic                gnt_busy_q, gnt_busy_d;
    logic [W_ID-1:0]     gnt_id_q, gnt_id_d;
    logic [W_ID-1:0]     rr_last_q, rr_last_d;
    logic [W_HP-1:0]     hp_cnt_q, hp_cnt_d;

    logic                any_lo_c;
    logic                hp_block_c;
    logic                win_found_c;
    logic [W_ID-1:0]     win_id_c;

    // Winner selection: bounded priority for 0, else round-robin over 1..N_REQ-1
    always_comb begin
        any_lo_c    = |req_valid[N_REQ-1:1];
        hp_block_c  = (hp_cnt_q == W_HP'(MAX_HIPRI)) && any_lo_c;
        win_found_c = 1'b0;
        win_id_c    = '0;
        if (req_valid[0] && !hp_block_c) begin
            win_found_c = 1'b1;
        end else begin
            // first pass: indices above rr_last; second pass wraps back to 1
            for (int i = 1; i < int'(N_REQ); i++) begin
                if (!win_found_c && req_valid[i] && (i > int'(rr_last_q))) begin
                    win_found_c = 1'b1;
                    win_id_c    = W_ID'(i);
                end
            end
            for (int i = 1; i < int'(N_REQ); i++) begin
                if (!win_found_c && req_valid[i]) begin
                    win_found_c = 1'b1;
                    win_id_c    = W_ID'(i);
                end
            end
        end
    end

    // Acceptance strobe back to the granted requester, same cycle as handshake
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            req_ready[i] = cmd_valid_q && cmd_ready && (gnt_id_q == W_ID'(i));
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_write_d = cmd_write_q;
        cmd_len_d   = cmd_len_q;
        gnt_busy_d  = gnt_busy_q;
        gnt_id_d    = gnt_id_q;
        rr_last_d   = rr_last_q;
        hp_cnt_d    = hp_cnt_q;

        case (state_q)
            IDLE: begin
                if (win_found_c) begin
                    for (int i = 0; i < int'(N_REQ); i++) begin
                        if (win_id_c == W_ID'(i)) begin
                            cmd_addr_d  = req_addr[i*W_ADDR +: W_ADDR];
                            cmd_write_d = req_write[i];
                            cmd_len_d   = req_len[i*W_LEN +: W_LEN];
                        end
                    end
                    gnt_id_d    = win_id_c;
                    gnt_busy_d  = 1'b1;
                    cmd_valid_d = 1'b1;
                    state_d     = ISSUE;
                    if (win_id_c == '0) begin
                        if (any_lo_c) begin
                            if (hp_cnt_q != W_HP'(MAX_HIPRI)) begin
                                hp_cnt_d = hp_cnt_q + W_HP'(1);
                            end
                        end else begin
                            hp_cnt_d = '0;
                        end
                    end else begin
                        hp_cnt_d  = '0;
                        rr_last_d = win_id_c;
                    end
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    if (ctrl_done) begin
                        gnt_busy_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        state_d    = BUSY;
                    end
                end
            end
            BUSY: begin
                if (ctrl_done) begin
                    gnt_busy_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_write_q <= 1'b0;
            cmd_len_q   <= '0;
            gnt_busy_q  <= 1'b0;
            gnt_id_q    <= '0;
            rr_last_q   <= W_ID'(N_REQ - 1);
            hp_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_write_q <= cmd_write_d;
            cmd_len_q   <= cmd_len_d;
            gnt_busy_q  <= gnt_busy_d;
            gnt_id_q    <= gnt_id_d;
            rr_last_q   <= rr_last_d;
            hp_cnt_q    <= hp_cnt_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_write = cmd_write_q;
    assign cmd_len   = cmd_len_q;
    assign gnt_busy  = gnt_busy_q;
    assign gnt_id    = gnt_id_q;

endmodule
